// File: rtl/sparse_acc_pkg.sv
// rtl/sparse_acc_pkg.sv - shared state encoding and widths for the sparse tile scheduler
package sparse_acc_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int SKIP_W    = 16;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    CAPTURE,
    LAUNCH,
    WAIT_DONE,
    GAP,
    NEXT,
    WB,
    DONE
  } sched_state_t;

endpackage

// File: rtl/tile_index_counter.sv
// rtl/tile_index_counter.sv - nested output-channel / input-tile index counter
module tile_index_counter #(
  parameter int NUM_OCH  = 8,
  parameter int NUM_TILE = 4,
  parameter int OCH_W    = 3,
  parameter int TILE_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_tile_adv,
  input  logic              i_och_adv,
  output logic [OCH_W-1:0]  o_och_idx,
  output logic [TILE_W-1:0] o_tile_idx,
  output logic              o_last_tile,
  output logic              o_last_och
);

  logic [OCH_W-1:0]  r_och;
  logic [TILE_W-1:0] r_tile;

  // The owner only advances when the matching last flag is low, so no wrap logic is needed here.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_och  <= '0;
      r_tile <= '0;
    end else if (i_och_adv) begin
      r_och  <= r_och + 1'b1;
      r_tile <= '0;
    end else if (i_tile_adv) begin
      r_tile <= r_tile + 1'b1;
    end
  end

  assign o_och_idx   = r_och;
  assign o_tile_idx  = r_tile;
  assign o_last_tile = (r_tile == TILE_W'(NUM_TILE - 1));
  assign o_last_och  = (r_och == OCH_W'(NUM_OCH - 1));

endmodule

// File: rtl/sparse_tile_scheduler.sv
// rtl/sparse_tile_scheduler.sv - layer sequencer: fetch counts, launch or skip tiles, write back channels
module sparse_tile_scheduler
  import sparse_acc_pkg::*;
#(
  parameter int NUM_OCH  = 8,
  parameter int NUM_TILE = 4,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int ADDR_W   = (NUM_OCH * NUM_TILE > 1) ? $clog2(NUM_OCH * NUM_TILE) : 1,
  parameter int OCH_W    = (NUM_OCH > 1) ? $clog2(NUM_OCH) : 1,
  parameter int TILE_W   = (NUM_TILE > 1) ? $clog2(NUM_TILE) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              cnt_rd_en,
  output logic [ADDR_W-1:0] cnt_rd_addr,
  input  logic [CNT_W-1:0]  act_cnt_in,
  input  logic [CNT_W-1:0]  wgt_cnt_in,
  output logic [CNT_W-1:0]  act_nz_count,
  output logic [CNT_W-1:0]  weight_nz_count,
  output logic              run_mcc,
  input  logic              mcc_done,
  output logic              acc_clear,
  output logic [OCH_W-1:0]  och_idx,
  output logic [TILE_W-1:0] tile_idx,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [OCH_W-1:0]  wb_och,
  output logic              layer_done,
  output logic [SKIP_W-1:0] skip_count
);

  sched_state_t      r_state;
  sched_state_t      w_state_nxt;
  logic [CNT_W-1:0]  r_act_cnt;
  logic [CNT_W-1:0]  r_wgt_cnt;
  logic [SKIP_W-1:0] r_skip_cnt;
  logic              w_clear;
  logic              w_tile_adv;
  logic              w_och_adv;
  logic              w_last_tile;
  logic              w_last_och;
  logic              w_cnt_zero;
  logic [OCH_W-1:0]  w_och;
  logic [TILE_W-1:0] w_tile;

  tile_index_counter #(
    .NUM_OCH  (NUM_OCH),
    .NUM_TILE (NUM_TILE),
    .OCH_W    (OCH_W),
    .TILE_W   (TILE_W)
  ) u_idx (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_clear),
    .i_tile_adv  (w_tile_adv),
    .i_och_adv   (w_och_adv),
    .o_och_idx   (w_och),
    .o_tile_idx  (w_tile),
    .o_last_tile (w_last_tile),
    .o_last_och  (w_last_och)
  );

  assign w_cnt_zero = (act_cnt_in == '0) || (wgt_cnt_in == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_tile_adv  = 1'b0;
    w_och_adv   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      FETCH:     w_state_nxt = CAPTURE;
      CAPTURE:   w_state_nxt = w_cnt_zero ? NEXT : LAUNCH;
      LAUNCH:    w_state_nxt = WAIT_DONE;
      WAIT_DONE: if (mcc_done) w_state_nxt = GAP;
      GAP:       w_state_nxt = NEXT;
      NEXT: begin
        if (!w_last_tile) begin
          w_tile_adv  = 1'b1;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = WB;
        end
      end
      WB: begin
        if (wb_ready) begin
          if (!w_last_och) begin
            w_och_adv   = 1'b1;
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counts are captured once per tile and held for the whole MAC pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_act_cnt  <= '0;
      r_wgt_cnt  <= '0;
      r_skip_cnt <= '0;
    end else begin
      if (w_clear) r_skip_cnt <= '0;
      if (r_state == CAPTURE) begin
        r_act_cnt <= act_cnt_in;
        r_wgt_cnt <= wgt_cnt_in;
        if (w_cnt_zero && (r_skip_cnt != '1)) r_skip_cnt <= r_skip_cnt + 1'b1;
      end
    end
  end

  assign busy            = (r_state != IDLE) && (r_state != DONE);
  assign cnt_rd_en       = (r_state == FETCH);
  assign cnt_rd_addr     = ADDR_W'(int'(w_och) * NUM_TILE + int'(w_tile));
  assign acc_clear       = (r_state == FETCH) && (w_tile == '0);
  assign run_mcc         = (r_state == LAUNCH) || (r_state == WAIT_DONE);
  assign wb_valid        = (r_state == WB);
  assign wb_och          = w_och;
  assign layer_done      = (r_state == DONE);
  assign och_idx         = w_och;
  assign tile_idx        = w_tile;
  assign act_nz_count    = r_act_cnt;
  assign weight_nz_count = r_wgt_cnt;
  assign skip_count      = r_skip_cnt;

endmodule

// File: tb/tb_sparse_tile_scheduler.sv
// tb/tb_sparse_tile_scheduler.sv - self-checking bench for sparse_tile_scheduler
module tb_sparse_tile_scheduler;

  localparam int A_NO    = 2;
  localparam int A_NT    = 2;
  localparam int A_N     = A_NO * A_NT;
  localparam int MAC_LAT = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic        a_start = 1'b0;
  logic        a_busy, a_rd_en, a_run, a_clr, a_wb_valid, a_done;
  logic [1:0]  a_rd_addr;
  logic [7:0]  a_act_in = 8'hEE;
  logic [7:0]  a_wgt_in = 8'hEE;
  logic [7:0]  a_act_nz, a_wgt_nz;
  logic        a_mcc_done = 1'b0;
  logic        a_wb_ready = 1'b1;
  logic        a_och, a_tile, a_wb_och;
  logic [15:0] a_skip;

  logic        b_start = 1'b0;
  logic        b_busy, b_rd_en, b_run, b_clr, b_wb_valid, b_done;
  logic [3:0]  b_rd_addr;
  logic [7:0]  b_act_nz, b_wgt_nz;
  logic [1:0]  b_och, b_tile, b_wb_och;
  logic [15:0] b_skip;

  sparse_tile_scheduler #(.NUM_OCH(A_NO), .NUM_TILE(A_NT), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .busy(a_busy),
    .cnt_rd_en(a_rd_en), .cnt_rd_addr(a_rd_addr),
    .act_cnt_in(a_act_in), .wgt_cnt_in(a_wgt_in),
    .act_nz_count(a_act_nz), .weight_nz_count(a_wgt_nz),
    .run_mcc(a_run), .mcc_done(a_mcc_done), .acc_clear(a_clr),
    .och_idx(a_och), .tile_idx(a_tile),
    .wb_valid(a_wb_valid), .wb_ready(a_wb_ready), .wb_och(a_wb_och),
    .layer_done(a_done), .skip_count(a_skip)
  );

  sparse_tile_scheduler #(.NUM_OCH(3), .NUM_TILE(3), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .busy(b_busy),
    .cnt_rd_en(b_rd_en), .cnt_rd_addr(b_rd_addr),
    .act_cnt_in(8'd0), .wgt_cnt_in(8'd0),
    .act_nz_count(b_act_nz), .weight_nz_count(b_wgt_nz),
    .run_mcc(b_run), .mcc_done(1'b0), .acc_clear(b_clr),
    .och_idx(b_och), .tile_idx(b_tile),
    .wb_valid(b_wb_valid), .wb_ready(1'b1), .wb_och(b_wb_och),
    .layer_done(b_done), .skip_count(b_skip)
  );

  int tbl_act[A_N];
  int tbl_wgt[A_N];
  int wb_hold = 0;
  bit spur_en = 1'b0;

  int launches, clr_cnt, wb_cyc, done_cnt, done_cyc;
  int wb_seq[$];
  int b_run_seen = 0, b_wb = 0, b_rd = 0, b_clr_cnt = 0, b_done_cnt = 0, b_done_cyc = 0, b_last_addr = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Count table: data appears only in the cycle after the read strobe, filler otherwise.
  initial begin
    bit rd_pend;
    int rd_addr_q;
    rd_pend = 1'b0;
    rd_addr_q = 0;
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        a_act_in = 8'(tbl_act[rd_addr_q]);
        a_wgt_in = 8'(tbl_wgt[rd_addr_q]);
      end else begin
        a_act_in = 8'hEE;
        a_wgt_in = 8'hEE;
      end
      rd_pend = a_rd_en;
      rd_addr_q = int'(a_rd_addr);
    end
  end

  initial begin
    int lat;
    lat = -1;
    forever begin
      @(negedge clk);
      a_mcc_done = 1'b0;
      if (!a_run) lat = -1;
      else if (lat < 0) lat = MAC_LAT;
      else lat--;
      if (lat == 0) a_mcc_done = 1'b1;
      if (spur_en && a_rd_en) a_mcc_done = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (a_wb_valid && wb_hold > 0) begin
      a_wb_ready = 1'b0;
      wb_hold--;
    end else begin
      a_wb_ready = 1'b1;
    end
  end

  // Timing model: each rule predicts when the next fetch, launch, write-back or done must appear.
  initial begin
    bit e_busy, e_rd, e_clr, e_run, e_wb, e_done, active, prev_run, skip_clear;
    int e_addr, e_wb_och, e_skip, e_pos, cur_l, c, n;
    int t_fetch, t_launch, t_after, t_wb, t_done, t_skip;
    {e_busy, e_rd, e_clr, e_run, e_wb, e_done, active, prev_run} = '0;
    e_addr = 0; e_wb_och = 0; e_skip = 0; e_pos = 0; cur_l = 0;
    t_fetch = -1; t_launch = -1; t_after = -1; t_wb = -1; t_done = -1; t_skip = -1;
    forever begin
      @(negedge clk);
      #1;
      chk("busy", a_busy, e_busy);
      chk("cnt_rd_en", a_rd_en, e_rd);
      chk("run_mcc", a_run, e_run);
      chk("wb_valid", a_wb_valid, e_wb);
      chk("layer_done", a_done, e_done);
      chk("acc_clear", a_clr, e_clr);
      chk("skip_count", a_skip, e_skip);
      if (e_rd) chk("cnt_rd_addr", a_rd_addr, e_addr);
      if (e_wb) chk("wb_och", a_wb_och, e_wb_och);
      if (e_run) begin
        chk("act_nz_count", a_act_nz, tbl_act[cur_l]);
        chk("weight_nz_count", a_wgt_nz, tbl_wgt[cur_l]);
      end
      if (a_run && !prev_run) launches++;
      prev_run = a_run;
      if (a_clr) clr_cnt++;
      if (a_wb_valid) wb_cyc++;
      if (a_wb_valid && a_wb_ready) wb_seq.push_back(int'(a_wb_och));
      if (a_done) begin
        done_cnt++;
        done_cyc = cyc;
      end

      c = cyc;
      n = c + 1;
      skip_clear = 1'b0;
      if (reset) begin
        {e_busy, e_rd, e_clr, e_run, e_wb, e_done, active} = '0;
        e_skip = 0;
        t_fetch = -1; t_launch = -1; t_after = -1; t_wb = -1; t_done = -1; t_skip = -1;
      end else begin
        if (!e_busy && !e_done && a_start) begin
          e_pos = 0;
          t_fetch = n;
          active = 1'b1;
          skip_clear = 1'b1;
        end
        if (e_rd) begin
          if (tbl_act[e_pos] == 0 || tbl_wgt[e_pos] == 0) begin
            t_skip = c + 2;
            t_after = c + 3;
          end else begin
            t_launch = c + 2;
            cur_l = e_pos;
          end
          e_pos++;
        end
        if (e_run && c > t_launch && a_mcc_done) t_after = c + 3;
        if (t_after == n) begin
          if (e_pos % A_NT == 0) t_wb = n;
          else t_fetch = n;
        end
        if (e_wb && a_wb_ready) begin
          if (e_pos == A_N) t_done = n;
          else t_fetch = n;
        end
        e_run = (n == t_launch) || (e_run && !(c > t_launch && a_mcc_done));
        e_wb = (n == t_wb) || (e_wb && !a_wb_ready);
        e_rd = (n == t_fetch);
        e_addr = e_pos;
        e_clr = e_rd && (e_pos % A_NT == 0);
        e_wb_och = (e_pos - 1) / A_NT;
        e_done = (n == t_done);
        if (e_done) active = 1'b0;
        e_busy = active;
        if (skip_clear) e_skip = 0;
        else if (n == t_skip && e_skip < 65535) e_skip++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (b_run) b_run_seen++;
    if (b_wb_valid) b_wb++;
    if (b_clr) b_clr_cnt++;
    if (b_rd_en) begin
      b_rd++;
      b_last_addr = int'(b_rd_addr);
    end
    if (b_done) begin
      b_done_cnt++;
      b_done_cyc = cyc;
    end
  end

  task automatic clr_stats();
    launches = 0; clr_cnt = 0; wb_cyc = 0; done_cnt = 0; done_cyc = 0;
    wb_seq.delete();
  endtask

  task automatic run_a(input int hold, input bit spur, input bit busy_starts, output int off);
    int s;
    int k;
    clr_stats();
    wb_hold = hold;
    spur_en = spur;
    @(negedge clk);
    a_start = 1'b1;
    s = cyc;
    @(negedge clk);
    a_start = 1'b0;
    if (busy_starts) begin
      for (int p = 0; p < 3; p++) begin
        repeat (4) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
      end
    end
    k = 0;
    while (done_cnt == 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("layer_done_seen", (done_cnt > 0) ? 1 : 0, 1);
    off = done_cyc - s;
    repeat (3) @(negedge clk);
    spur_en = 1'b0;
  endtask

  task automatic fill(input int act, input int wgt);
    for (int i = 0; i < A_N; i++) begin
      tbl_act[i] = act;
      tbl_wgt[i] = wgt;
    end
  endtask

  initial begin
    int off;
    int k;
    int s;
    fill(3, 4);
    clr_stats();
    repeat (3) @(negedge clk);
    chk("rst_act_nz", a_act_nz, 0);
    chk("rst_wgt_nz", a_wgt_nz, 0);
    chk("rst_och", a_och, 0);
    chk("rst_tile", a_tile, 0);
    chk("rst_wb_och", a_wb_och, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_skip", b_skip, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_a(0, 1'b0, 1'b0, off);
    chk("t1_launches", launches, 4);
    chk("t1_clears", clr_cnt, 2);
    chk("t1_wb_count", wb_seq.size(), 2);
    chk("t1_wb0", (wb_seq.size() > 0) ? wb_seq[0] : -1, 0);
    chk("t1_wb1", (wb_seq.size() > 1) ? wb_seq[1] : -1, 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_skip", a_skip, 0);
    chk("t1_latency", off, 43);

    tbl_act[2] = 0;
    run_a(0, 1'b0, 1'b0, off);
    chk("t2_launches", launches, 3);
    chk("t2_skip", a_skip, 1);
    chk("t2_clears", clr_cnt, 2);
    chk("t2_latency", off, 36);

    fill(3, 4);
    run_a(7, 1'b0, 1'b0, off);
    chk("t3_wb_cycles", wb_cyc, 9);
    chk("t3_launches", launches, 4);
    chk("t3_latency", off, 50);

    clr_stats();
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    k = 0;
    while (!a_run && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t4_run_seen", a_run, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4_run_after_rst", a_run, 0);
    chk("t4_busy_after_rst", a_busy, 0);
    chk("t4_och_after_rst", a_och, 0);
    chk("t4_tile_after_rst", a_tile, 0);
    repeat (30) @(negedge clk);
    chk("t4_no_done", done_cnt, 0);
    run_a(0, 1'b0, 1'b0, off);
    chk("t4_rerun_launches", launches, 4);
    chk("t4_rerun_latency", off, 43);

    run_a(0, 1'b1, 1'b1, off);
    chk("t5_launches", launches, 4);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_latency", off, 43);
    chk("t5_wb1", (wb_seq.size() > 1) ? wb_seq[1] : -1, 1);

    @(negedge clk);
    b_start = 1'b1;
    s = cyc;
    @(negedge clk);
    b_start = 1'b0;
    k = 0;
    while (b_done_cnt == 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("t6_done_cnt", b_done_cnt, 1);
    chk("t6_latency", b_done_cyc - s, 31);
    chk("t6_skip", b_skip, 9);
    chk("t6_wb", b_wb, 3);
    chk("t6_run_seen", b_run_seen, 0);
    chk("t6_reads", b_rd, 9);
    chk("t6_clears", b_clr_cnt, 3);
    chk("t6_last_addr", b_last_addr, 8);
    chk("t6_wb_och", b_wb_och, 2);
    chk("t6_tile", b_tile, 2);
    chk("t6_och", b_och, 2);
    chk("t6_act_nz", b_act_nz, 0);
    chk("t6_wgt_nz", b_wgt_nz, 0);
    chk("t6_busy", b_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
